div_top: RTL and testbench
==========================

// Module: div_top
// PURPOSE
//  RV32M divide/remainder unit (DIV, DIVU, REM, REMU): the inverse counterpart of the multiply unit.
//  Sits beside the multiplier in the M extension. Uses the same start/done handshake towards the
//  execute stage.
//  Iterative radix-2 restoring divider: one quotient bit per clock, with sign fix-up and RISC-V
//  special-case results.
// PARAMETERS
//  DATA_W   `XLEN (32)   operand/result width; iteration count = DATA_W
// PORTS
//  i_clk    in   1       clock; all state updates on rising edge
//  i_rst    in   1       synchronous reset, active-high
//  i_start  in   1       start request; sampled only in IDLE or DONE
//  i_f3     in   3       funct3: `DIV / `DIVU / `REM / `REMU
//  i_rs1    in   DATA_W  dividend
//  i_rs2    in   DATA_W  divisor
//  o_busy   out  1       high in PREP/BUSY/FIX; start ignored while high
//  o_done   out  1       one-cycle pulse; o_res valid in that cycle
//  o_res    out  DATA_W  quotient (DIV/DIVU) or remainder (REM/REMU); held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, o_busy=0, o_done=0, o_res=0, counter=0. i_rst mid-operation aborts: no o_done.
//  Cycle 0 = cycle in which i_start=1 is accepted; operands and f3 registered at its edge.
//  FSM:
//   IDLE -> PREP on i_start.
//   PREP (cycle 1): record signs for DIV/REM and take magnitudes (|0x80000000| = 0x80000000
//    unsigned); detect special cases.
//    Special case -> result registered, go to DONE. Otherwise load remainder=0, quotient=|a|, cnt=0,
//    go to BUSY.
//   BUSY (cycles 2..DATA_W+1): shift {rem,quo} left 1; trial = rem - |b| (DATA_W+1 bits).
//    If non-negative, keep the difference and set quo[0]=1. cnt++; go to FIX after cnt==DATA_W-1.
//   FIX (cycle DATA_W+2): quotient negated if sign(a)!=sign(b) (signed ops only); remainder takes
//    sign(a). Selected result registered into o_res. -> DONE.
//   DONE: o_done=1 for exactly this cycle (cycle DATA_W+3 = 35 normal, 2 for special cases).
//    Next state is IDLE, or PREP if i_start=1 (back-to-back issue allowed).
//  Special cases (always 2-cycle latency):
//   divisor==0: DIV/DIVU -> all ones; REM/REMU -> dividend unchanged.
//   signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
//  i_start while o_busy=1 is ignored; input changes after acceptance do not affect the result.
//  Unsupported i_f3 (MUL group) is treated as DIVU; the decoder is responsible for not issuing it.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   PREP also detects |a| < |b| (b != 0). Result: quotient=0, remainder=a (original signed
//   value); o_done at cycle 2.
//  DIV_EARLY_OUT_EN undefined:
//   such operands run the full iteration; identical results at cycle 35.
//  Results are bit-identical in both builds; only latency differs.
// STRUCTURE
//  `DIV/`DIVU/`REM/`REMU funct3 codes live in extensions/m/m-isa.vh.
//  Local FSM state encodings stay in this module.
//  div_top owns f3 decode, sign handling, special cases and the FSM.
//  One sub-module, div_core: unsigned DATA_W-bit restoring datapath (rem/quo registers, trial
//  subtract, counter), with load/step/last ports.
// TESTING
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; o_done high exactly cycle 35, o_busy high
//   cycles 1..34.
//  DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; REMU 100/7 -> 2; REM 7/-2 -> 1; DIV 7/-2 -> 0xFFFFFFFD.
//  Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; REMU 0x80000000/0 -> 0x80000000;
//   all with o_done at cycle 2.
//  Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; done at cycle 2.
//  Reset/handshake: i_rst at cycle 10 -> next cycle o_busy=0, o_done=0, o_res=0, no later done.
//   i_start re-pulsed at cycle 5 of an op -> ignored, single done at 35.
//   Start in the DONE cycle -> next done 35 cycles later.
//  With DIV_EARLY_OUT_EN: DIVU 3/10 -> 0 at cycle 2; REM -3/10 -> 0xFFFFFFFD at cycle 2.
//   Without the macro: same values at cycle 35.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide unit.
// funct3 codes for the divide group and the operation decode helper.
package div_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef struct packed {
    logic sgn;
    logic rem;
  } div_op_t;

  // MUL-group codes fall through as DIVU
  function automatic div_op_t div_decode(
    input logic [2:0] f3
  );
    div_op_t op;
    op.sgn = (f3 == F3_DIV) || (f3 == F3_REM);
    op.rem = (f3 == F3_REM) || (f3 == F3_REMU);
    return op;
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divide datapath.
// One quotient bit per step; remainder/quotient/counter registers.
module div_core
  import div_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quo,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_last
);

  localparam int CW = $clog2(DATA_W);

  logic [CW-1:0]     cnt;
  logic [DATA_W:0]   sh;
  logic              ge;
  logic [DATA_W-1:0] diff;

  assign sh     = {o_rem, o_quo[DATA_W-1]};
  assign ge     = sh >= {1'b0, i_divisor};
  assign diff   = sh[DATA_W-1:0] - i_divisor;
  assign o_last = (cnt == CW'(DATA_W-1));

  // load operands, then shift/subtract one bit per step
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rem <= '0;
      o_quo <= '0;
      cnt   <= '0;
    end else if (i_load) begin
      o_rem <= '0;
      o_quo <= i_dividend;
      cnt   <= '0;
    end else if (i_step) begin
      o_rem <= ge ? diff : sh[DATA_W-1:0];
      o_quo <= {o_quo[DATA_W-2:0], ge};
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/div_top.sv
// RV32M DIV/DIVU/REM/REMU unit: sign handling, special cases, FSM.
// Optional early-out for |a| < |b| under `define DIV_EARLY_OUT_EN.
module div_top
  import div_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_f3,
  input  logic [DATA_W-1:0] i_rs1,
  input  logic [DATA_W-1:0] i_rs2,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_res
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state;
  state_t            state_d;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  div_op_t           op_q;
  logic              accept;
  logic              load;
  logic              step;
  logic              res_we;
  logic [DATA_W-1:0] res_d;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic              last;
  logic              sa;
  logic              sb;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              b_zero;
  logic              ovf;
  logic              early;
  logic              special;
  logic [DATA_W-1:0] spec_res;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  assign accept = i_start &&
                  (state == S_IDLE || state == S_DONE);
  assign o_busy = (state == S_PREP) ||
                  (state == S_BUSY) ||
                  (state == S_FIX);
  assign o_done = (state == S_DONE);

  assign sa    = op_q.sgn & a_q[DATA_W-1];
  assign sb    = op_q.sgn & b_q[DATA_W-1];
  assign a_mag = sa ? -a_q : a_q;
  assign b_mag = sb ? -b_q : b_q;

  assign b_zero = (b_q == '0);
  assign ovf    = op_q.sgn && (a_q == MIN_NEG) && (b_q == '1);
`ifdef DIV_EARLY_OUT_EN
  assign early  = !b_zero && (a_mag < b_mag);
`else
  assign early  = 1'b0;
`endif
  assign special = b_zero | ovf | early;

  assign q_fix = (sa ^ sb) ? -quo : quo;
  assign r_fix = sa ? -rem : rem;

  // short-circuit results for zero divisor, overflow, early-out
  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      b_zero:  spec_res = op_q.rem ? a_q : '1;
      ovf:     spec_res = op_q.rem ? '0 : a_q;
      default: spec_res = op_q.rem ? a_q : '0;
    endcase
  end

  div_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (load),
    .i_step    (step),
    .i_dividend(a_mag),
    .i_divisor (b_mag),
    .o_quo     (quo),
    .o_rem     (rem),
    .o_last    (last)
  );

  // next-state and datapath controls
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    res_we  = 1'b0;
    res_d   = spec_res;
    unique case (state)
      S_IDLE: begin
        if (i_start) state_d = S_PREP;
      end
      S_PREP: begin
        if (special) begin
          res_we  = 1'b1;
          state_d = S_DONE;
        end else begin
          load    = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        step = 1'b1;
        if (last) state_d = S_FIX;
      end
      S_FIX: begin
        res_we  = 1'b1;
        res_d   = op_q.rem ? r_fix : q_fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = i_start ? S_PREP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, captured operands and result register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      o_res <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_q  <= i_rs1;
        b_q  <= i_rs2;
        op_q <= div_decode(i_f3);
      end
      if (res_we) o_res <= res_d;
    end
  end

endmodule

// File: tb/tb_div_top.sv
// Directed bench for div_top.
// Latency of |a|<|b| cases follows DIV_EARLY_OUT_EN.
module tb_div_top;
  import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 35;
`endif

  typedef struct {
    string       tag;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  f3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  div_top dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_f3   (f3),
    .i_rs1  (rs1),
    .i_rs2  (rs2),
    .o_busy (busy),
    .o_done (done),
    .o_res  (res)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // issue one op; returns done cycle (-1 on timeout)
  task automatic run_op(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          b2b,
    output int          lat,
    output int          nbusy,
    output logic [31:0] r
  );
    if (!b2b) @(negedge clk);
    start = 1'b1;
    f3    = op;
    rs1   = a;
    rs2   = b;
    @(negedge clk);
    start = 1'b0;
    f3    = 3'b011;
    rs1   = $urandom;
    rs2   = $urandom;
    lat   = -1;
    nbusy = 0;
    for (int c = 1; c < 60; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
    r = res;
  endtask

  initial begin
    int          lat;
    int          nb;
    int          ndone;
    int          first;
    logic [31:0] r;
    logic [31:0] r1;

    vecs.push_back('{"div -7/2", F3_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 35});
    vecs.push_back('{"rem -7/2", F3_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 35});
    vecs.push_back('{"divu max/1", F3_DIVU, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 35});
    vecs.push_back('{"remu 100/7", F3_REMU, 32'd100, 32'd7, 32'd2, 35});
    vecs.push_back('{"rem 7/-2", F3_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 35});
    vecs.push_back('{"div 7/-2", F3_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 35});
    vecs.push_back('{"div -8/-3", F3_DIV, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2, 35});
    vecs.push_back('{"rem -8/-3", F3_REM, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 35});
    vecs.push_back('{"div min/1", F3_DIV, 32'h80000000, 32'h1, 32'h80000000, 35});
    vecs.push_back('{"divu max/min", F3_DIVU, 32'hFFFFFFFF, 32'h80000000, 32'h1, 35});
    vecs.push_back('{"remu max/min", F3_REMU, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 35});
    vecs.push_back('{"f3=000 as divu", 3'b000, 32'd20, 32'd6, 32'd3, 35});
    vecs.push_back('{"div 5/0", F3_DIV, 32'd5, 32'h0, 32'hFFFFFFFF, 2});
    vecs.push_back('{"rem -5/0", F3_REM, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 2});
    vecs.push_back('{"remu min/0", F3_REMU, 32'h80000000, 32'h0, 32'h80000000, 2});
    vecs.push_back('{"div ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
    vecs.push_back('{"rem ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2});
    vecs.push_back('{"divu 3/10", F3_DIVU, 32'd3, 32'd10, 32'd0, EO_LAT});
    vecs.push_back('{"rem -3/10", F3_REM, 32'hFFFFFFFD, 32'd10, 32'hFFFFFFFD, EO_LAT});

    rst   = 1'b1;
    start = 1'b0;
    f3    = 3'b000;
    rs1   = '0;
    rs2   = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset res", res, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0, lat, nb, r);
      check(vecs[i].tag, r, vecs[i].exp);
      check({vecs[i].tag, " lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].tag, " busy"}, 32'(nb), 32'(vecs[i].lat - 1));
      check({vecs[i].tag, " busy@done"}, 32'(busy), 32'd0);
    end

    // reset mid-operation
    @(negedge clk);
    start = 1'b1;
    f3    = F3_DIVU;
    rs1   = 32'd1000;
    rs2   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort res", res, 32'd0);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);

    // start re-pulsed while busy
    start = 1'b1;
    f3    = F3_DIV;
    rs1   = 32'hFFFFFFF9;
    rs2   = 32'h2;
    ndone = 0;
    first = -1;
    r1    = '0;
    for (int c = 1; c < 70; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (c == 5) begin
        f3  = F3_REMU;
        rs1 = 32'd100;
        rs2 = 32'd7;
      end
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = c;
          r1    = res;
        end
      end
    end
    check("repulse ndone", 32'(ndone), 32'd1);
    check("repulse lat", 32'(first), 32'd35);
    check("repulse res", r1, 32'hFFFFFFFD);

    // back-to-back issue from the DONE cycle
    run_op(F3_DIVU, 32'd100, 32'd7, 1'b0, lat, nb, r);
    check("b2b first", r, 32'd14);
    check("b2b first lat", 32'(lat), 32'd35);
    run_op(F3_REMU, 32'd100, 32'd7, 1'b1, lat, nb, r);
    check("b2b second", r, 32'd2);
    check("b2b second lat", 32'(lat), 32'd35);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
